// File: rtl/toy_bus_slice2ch_node_fetch.sv
// Two-channel register slice in front of the fetch-node decoder/arbiter:
// full-throughput skid buffers on request and ack, plus an outstanding-request throttle.

module toy_bus_slice2ch_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_en_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_data_o
);
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire;
  logic         out_fire;

  // Ready depends only on flops, so no combinational path crosses the slice.
  assign in_rdy_o   = !skid_vld_q && in_en_i;
  assign in_fire    = in_vld_i && in_rdy_o;
  assign out_fire   = main_vld_q && out_rdy_i;
  assign out_vld_o  = main_vld_q;
  assign out_data_o = main_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        main_d     = in_data_i;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_d     = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
endmodule

module toy_bus_slice2ch_node_fetch #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_req_vld,
  output logic             in0_req_rdy,
  input  logic [31:0]      in0_req_addr,
  input  logic [31:0]      in0_req_strb,
  input  logic [255:0]     in0_req_data,
  input  logic             in0_req_opcode,
  input  logic [3:0]       in0_req_src_id,
  input  logic [3:0]       in0_req_tgt_id,
  input  logic [31:0]      in0_req_sideband,
  output logic             out0_req_vld,
  input  logic             out0_req_rdy,
  output logic [31:0]      out0_req_addr,
  output logic [31:0]      out0_req_strb,
  output logic [255:0]     out0_req_data,
  output logic             out0_req_opcode,
  output logic [3:0]       out0_req_src_id,
  output logic [3:0]       out0_req_tgt_id,
  output logic [31:0]      out0_req_sideband,
  output logic             in0_ack_vld,
  input  logic             in0_ack_rdy,
  output logic             in0_ack_opcode,
  output logic [255:0]     in0_ack_data,
  output logic [31:0]      in0_ack_sideband,
  output logic [3:0]       in0_ack_src_id,
  output logic [3:0]       in0_ack_tgt_id,
  input  logic             out0_ack_vld,
  output logic             out0_ack_rdy,
  input  logic             out0_ack_opcode,
  input  logic [255:0]     out0_ack_data,
  input  logic [31:0]      out0_ack_sideband,
  input  logic [3:0]       out0_ack_src_id,
  input  logic [3:0]       out0_ack_tgt_id,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_ack_underflow
);
  localparam int REQ_W = 361;
  localparam int ACK_W = 297;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [REQ_W-1:0] req_out;
  logic [ACK_W-1:0] ack_out;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             req_en;
  logic             req_hs;
  logic             ack_hs;

  assign req_en = (cnt_q < MAX_CNT);
  assign req_hs = in0_req_vld && in0_req_rdy;
  assign ack_hs = in0_ack_vld && in0_ack_rdy;

  toy_bus_slice2ch_skid #(.W(REQ_W)) u_req (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_en_i    (req_en),
    .in_vld_i   (in0_req_vld),
    .in_rdy_o   (in0_req_rdy),
    .in_data_i  ({in0_req_addr, in0_req_strb, in0_req_data, in0_req_opcode,
                  in0_req_src_id, in0_req_tgt_id, in0_req_sideband}),
    .out_vld_o  (out0_req_vld),
    .out_rdy_i  (out0_req_rdy),
    .out_data_o (req_out)
  );

  assign {out0_req_addr, out0_req_strb, out0_req_data, out0_req_opcode,
          out0_req_src_id, out0_req_tgt_id, out0_req_sideband} = req_out;

  toy_bus_slice2ch_skid #(.W(ACK_W)) u_ack (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_en_i    (1'b1),
    .in_vld_i   (out0_ack_vld),
    .in_rdy_o   (out0_ack_rdy),
    .in_data_i  ({out0_ack_opcode, out0_ack_data, out0_ack_sideband,
                  out0_ack_src_id, out0_ack_tgt_id}),
    .out_vld_o  (in0_ack_vld),
    .out_rdy_i  (in0_ack_rdy),
    .out_data_o (ack_out)
  );

  assign {in0_ack_opcode, in0_ack_data, in0_ack_sideband,
          in0_ack_src_id, in0_ack_tgt_id} = ack_out;

  // An ack with nothing outstanding flags the error and the count holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (ack_hs && (cnt_q == '0)) err_d = 1'b1;
    if (req_hs && !ack_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!req_hs && ack_hs && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign outstanding       = cnt_q;
  assign err_ack_underflow = err_q;
endmodule

// File: doc/toy_bus_slice2ch_node_fetch.md
Name: toy_bus_slice2ch_node_fetch

Overview:
Two-channel pipeline register slice that sits directly upstream of the fetch-node request decoder / ack arbiter pair.
- Forward (ToyBusReq) channel: registers the request toward the decoder.
- Backward (ToyBusAck) channel: registers the merged ack returning to the fetch master.
- Both channels are full-throughput 2-entry skid buffers, so all ready paths are registered.
- An outstanding-transaction counter throttles new requests once MAX_OUT requests are unacknowledged.

Parameters:
- MAX_OUT, 4: maximum unacknowledged requests (legal range 1..15).
- CNT_W, 4: counter width. Must hold MAX_OUT; a fixed value of 4 covers the full range.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in0_req_vld  input  1  upstream request valid.
- in0_req_rdy  output  1  upstream request ready.
- in0_req_{addr,strb,data,opcode,src_id,tgt_id,sideband}  input  32/32/256/1/4/4/32  upstream request payload.
- out0_req_vld  output  1  request valid toward decoder.
- out0_req_rdy  input  1  decoder ready.
- out0_req_{addr,strb,data,opcode,src_id,tgt_id,sideband}  output  32/32/256/1/4/4/32  registered request payload.
- in0_ack_vld  output  1  ack valid toward upstream master.
- in0_ack_rdy  input  1  upstream master ack ready.
- in0_ack_{opcode,data,sideband,src_id,tgt_id}  output  1/256/32/4/4  registered ack payload.
- out0_ack_vld  input  1  ack valid from arbiter.
- out0_ack_rdy  output  1  ready to arbiter.
- out0_ack_{opcode,data,sideband,src_id,tgt_id}  input  1/256/32/4/4  ack payload from arbiter.
- outstanding  output  CNT_W  current unacknowledged request count.
- err_ack_underflow  output  1  sticky: an ack was accepted while outstanding==0.

Behaviour:
- Handshake on every interface is vld&&rdy in the same cycle. A valid, once asserted, holds with a stable payload until accepted.
- Skid buffer, per channel:
  - Two entries: main and skid, each with a valid bit.
  - Output is driven from main; main load happens on the clock edge after input acceptance.
  - Input-to-output latency is 1 cycle.
  - Input ready is the registered value !skid_vld.
  - If the input is accepted while main is valid and the output is not accepted, the beat goes to skid.
  - When main drains and skid is valid, skid moves to main.
  - Payload order is strictly FIFO. Sustained throughput is 1 beat/cycle when downstream is always ready.
- Request throttle:
  - in0_req_rdy = !req_skid_vld && (outstanding < MAX_OUT).
  - outstanding increments on the in0_req handshake and decrements on the in0_ack handshake.
  - A simultaneous increment and decrement leaves outstanding unchanged.
- Underflow:
  - An ack handshake while outstanding==0 sets err_ack_underflow, and outstanding stays 0 (no wrap).
  - err_ack_underflow is cleared only by reset.
- Ack channel: never throttled by the counter. out0_ack_rdy = !ack_skid_vld.
- Reset (async assert, sync-released by the system):
  - All valid bits 0, so out0_req_vld=0 and in0_ack_vld=0.
  - outstanding=0, err_ack_underflow=0.
  - in0_req_rdy=1 and out0_ack_rdy=1 from the first cycle after reset deassertion.
  - Payload registers are not reset. Payload outputs are don't-care while the corresponding valid is 0.
- Reset mid-operation: buffered beats are discarded and the counter returns to 0; no partial output persists.
- Payload fields pass bit-exact; no field is modified or interpreted.

Test Plan:
1. Streaming: one request per cycle for 8 cycles, out0_req_rdy=1, acks returned 2 cycles later. Required: out0_req beats identical to the inputs with addr 0x0..0x1C, each appearing 1 cycle after acceptance; outstanding never exceeds 3; in0_req_rdy stays 1.
2. Backpressure: out0_req_rdy=0 with 3 requests offered. Required:
   - Beats A and B are accepted; in0_req_rdy falls the cycle after B.
   - C is held.
   - On release, A, B, C emerge in order over 3 consecutive cycles with no loss or duplication.
3. Throttle: MAX_OUT=4, 5 requests offered, no acks. Required:
   - 4 requests are accepted; outstanding=4; in0_req_rdy=0 with the 5th held.
   - One ack accepted: the 5th request is accepted the same cycle in0_req_rdy rises; outstanding stays 4.
4. Simultaneous events: a request accepted and an ack accepted in the same cycle at outstanding=2. Required: outstanding=2 next cycle.
5. Underflow: an ack with data=0xDEAD_BEEF… injected at outstanding=0. Required: the ack is delivered on in0_ack with data unchanged; err_ack_underflow=1 and stays 1; outstanding=0.
6. Mid-operation reset: rst_n pulsed low while both skid buffers are full. Required: all valids 0 immediately (asynchronously); outstanding=0; both readies 1 after release; no stale beat appears afterward.
